norm_result_collector: RTL and testbench

Receive-side collector for the vector-normalization datapath. Captures the four per-lane quotients (A, B, C, D) when all four lane valids fire together and buffers whole vectors in a small FIFO. Replays each vector as four beats on a single ready/valid stream. Absorbs the datapath's lack of backpressure and flags dropped or misaligned results.

---
 rtl/norm_result_collector_if.sv | 39 +++
 rtl/norm_result_collector.sv | 113 +++++++++++
 tb/tb_norm_result_collector.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/norm_result_collector_if.sv
// Stream-side bundle for norm_result_collector: four per-lane result inputs
// from the datapath and the single ready/valid output stream.
interface norm_result_collector_if #(
    parameter int unsigned DATAWIDTH  = 16,
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned CountW = $clog2(FIFO_DEPTH) + 1;

    logic                 i_valid_A;
    logic                 i_valid_B;
    logic                 i_valid_C;
    logic                 i_valid_D;
    logic [DATAWIDTH:0]   i_data_A;
    logic [DATAWIDTH:0]   i_data_B;
    logic [DATAWIDTH:0]   i_data_C;
    logic [DATAWIDTH:0]   i_data_D;
    logic                 o_valid;
    logic                 i_ready;
    logic [DATAWIDTH:0]   o_data;
    logic [1:0]           o_lane;
    logic                 o_last;
    logic [CountW-1:0]    o_count;
    logic                 o_overflow;
    logic                 o_lane_mismatch;

    modport slave (
        input  i_valid_A, i_valid_B, i_valid_C, i_valid_D,
        input  i_data_A, i_data_B, i_data_C, i_data_D,
        input  i_ready,
        output o_valid, o_data, o_lane, o_last, o_count, o_overflow, o_lane_mismatch
    );

    modport master (
        output i_valid_A, i_valid_B, i_valid_C, i_valid_D,
        output i_data_A, i_data_B, i_data_C, i_data_D,
        output i_ready,
        input  o_valid, o_data, o_lane, o_last, o_count, o_overflow, o_lane_mismatch
    );
endinterface

// File: rtl/norm_result_collector.sv
// Captures four-lane normalization results into a vector FIFO and replays each
// vector as four beats (A, B, C, D) on one ready/valid stream.
module norm_result_collector #(
    parameter int unsigned DATAWIDTH   = 16,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned INSTANCE_ID = 0
) (
    input logic                    clk,
    input logic                    rst,
    norm_result_collector_if.slave bus
);
    localparam int unsigned LaneW  = DATAWIDTH + 1;
    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CountW = PtrW + 1;
    localparam logic [CountW-1:0] DepthC = CountW'(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("norm_result_collector %0d: FIFO_DEPTH must be a power of two >= 2",
               INSTANCE_ID);
    end

    typedef logic [3:0][LaneW-1:0] vec_t;
    typedef enum logic {StIdle, StSend} state_e;

    state_e            state_q, state_d;
    vec_t              mem_q [FIFO_DEPTH];
    vec_t              hold_q;
    vec_t              vec_in;
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CountW-1:0] count_q;
    logic [1:0]        lane_q;
    logic              overflow_q, mismatch_q;
    logic [3:0]        valids;
    logic              all_valid, some_valid, fifo_empty, fifo_full;
    logic              beat_done, pop, push;

    // Element 0 is lane A so the beat index selects the lane directly.
    assign valids     = {bus.i_valid_D, bus.i_valid_C, bus.i_valid_B, bus.i_valid_A};
    assign vec_in     = {bus.i_data_D, bus.i_data_C, bus.i_data_B, bus.i_data_A};
    assign all_valid  = &valids;
    assign some_valid = (|valids) && !all_valid;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DepthC);
    assign beat_done  = (state_q == StSend) && bus.i_ready;

    // Pop decisions use the pre-edge count, so a vector captured this cycle never bypasses.
    assign pop  = !fifo_empty && ((state_q == StIdle) || (beat_done && lane_q == 2'd3));
    assign push = all_valid && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (!fifo_empty) state_d = StSend;
            StSend:  if (beat_done && lane_q == 2'd3 && fifo_empty) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.o_valid = 1'b0;
        bus.o_last  = 1'b0;
        bus.o_lane  = lane_q;
        bus.o_data  = hold_q[lane_q];
        if (state_q == StSend) begin
            bus.o_valid = 1'b1;
            bus.o_last  = (lane_q == 2'd3);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            hold_q     <= '0;
            lane_q     <= '0;
            overflow_q <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (push && !pop) begin
                count_q <= count_q + CountW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CountW'(1);
            end
            if (pop) begin
                hold_q <= mem_q[rd_ptr_q];
                lane_q <= '0;
            end else if (beat_done && lane_q != 2'd3) begin
                lane_q <= lane_q + 2'd1;
            end
            if (all_valid && !push) overflow_q <= 1'b1;
            if (some_valid)         mismatch_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= vec_in;
    end

    assign bus.o_count         = count_q;
    assign bus.o_overflow      = overflow_q;
    assign bus.o_lane_mismatch = mismatch_q;
endmodule

// File: tb/tb_norm_result_collector.sv
// Randomized and directed bench for norm_result_collector: a queue-based reference
// model predicts accepted vectors; a negedge monitor checks beats from a scoreboard.
module tb_norm_result_collector;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = DW + 1;

    typedef logic [3:0][LW-1:0] vec_t;
    typedef struct packed {
        logic [LW-1:0] data;
        logic [1:0]    lane;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    norm_result_collector_if #(.DATAWIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

    norm_result_collector #(
        .DATAWIDTH  (DW),
        .FIFO_DEPTH (DEPTH),
        .INSTANCE_ID(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: vector queue, held vector, beat position, sticky flags.
    vec_t  m_q[$];
    vec_t  m_held;
    bit    m_busy = 1'b0;
    int    m_lane = 0;
    bit    m_ovf  = 1'b0;
    bit    m_mis  = 1'b0;
    beat_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        sb.delete();
        m_held = '0;
        m_busy = 1'b0;
        m_lane = 0;
        m_ovf  = 1'b0;
        m_mis  = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] v, input vec_t d, input logic rdy);
        int nv = $countones(v);
        int sz = m_q.size();
        bit pop;
        bit wr;
        pop = (sz != 0) && (!m_busy || (rdy && m_lane == 3));
        if (pop) begin
            m_held = m_q.pop_front();
            m_busy = 1'b1;
            m_lane = 0;
        end else if (m_busy && rdy) begin
            if (m_lane == 3) m_busy = 1'b0;
            else m_lane++;
        end
        wr = (nv == 4) && (sz < int'(DEPTH) || pop);
        if (wr) begin
            m_q.push_back(d);
            for (int i = 0; i < 4; i++) begin
                sb.push_back('{data: d[i], lane: 2'(i), last: (i == 3)});
            end
        end else if (nv == 4) begin
            m_ovf = 1'b1;
        end
        if (nv >= 1 && nv <= 3) m_mis = 1'b1;
    endtask

    task automatic drive(input logic [3:0] v, input vec_t d, input logic rdy);
        bus.i_valid_A = v[0];
        bus.i_valid_B = v[1];
        bus.i_valid_C = v[2];
        bus.i_valid_D = v[3];
        bus.i_data_A  = d[0];
        bus.i_data_B  = d[1];
        bus.i_data_C  = d[2];
        bus.i_data_D  = d[3];
        bus.i_ready   = rdy;
        @(posedge clk);
        if (rst) model_reset();
        else model_step(v, d, rdy);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(4'h0, '0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic idle(input int n, input logic rdy);
        repeat (n) drive(4'h0, '0, rdy);
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < 4; i++) v[i] = LW'($urandom);
        return v;
    endfunction

    task automatic drain();
        int k = 0;
        while ((m_q.size() != 0 || m_busy) && k < 200) begin
            drive(4'h0, '0, 1'b1);
            k++;
        end
        check("drain_bound", 32'(k < 200), 32'd1);
        check("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: per-cycle state vs model, beat payload vs scoreboard, stall stability.
    logic [LW-1:0] p_data;
    logic [1:0]    p_lane;
    logic          p_last;
    bit            p_stall = 1'b0;
    beat_t         exp_beat;

    always @(negedge clk) begin
        if (p_stall) begin
            check("stall_data", 32'(bus.o_data), 32'(p_data));
            check("stall_lane", 32'(bus.o_lane), 32'(p_lane));
            check("stall_last", 32'(bus.o_last), 32'(p_last));
        end
        check("o_valid", 32'(bus.o_valid), 32'(m_busy));
        check("o_count", 32'(bus.o_count), 32'(m_q.size()));
        check("o_overflow", 32'(bus.o_overflow), 32'(m_ovf));
        check("o_lane_mismatch", 32'(bus.o_lane_mismatch), 32'(m_mis));
        if (bus.o_valid === 1'b1 && bus.i_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL beat_unexpected: got lane %0d data 0x%0h required no beat",
                         bus.o_lane, bus.o_data);
            end else begin
                exp_beat = sb.pop_front();
                check("beat_data", 32'(bus.o_data), 32'(exp_beat.data));
                check("beat_lane", 32'(bus.o_lane), 32'(exp_beat.lane));
                check("beat_last", 32'(bus.o_last), 32'(exp_beat.last));
            end
        end
        p_stall = (bus.o_valid === 1'b1) && (bus.i_ready === 1'b0) && !rst;
        p_data  = bus.o_data;
        p_lane  = bus.o_lane;
        p_last  = bus.o_last;
    end

    vec_t v1;
    vec_t vb;
    vec_t vnew;

    initial begin
        // Reset state
        do_reset();
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check("rst_data", 32'(bus.o_data), 32'd0);
        check("rst_lane", 32'(bus.o_lane), 32'd0);
        check("rst_last", 32'(bus.o_last), 32'd0);
        check("rst_count", 32'(bus.o_count), 32'd0);

        // Single vector with latency
        v1[0] = 17'h00100;
        v1[1] = 17'h00080;
        v1[2] = 17'h00040;
        v1[3] = 17'h1FFFF;
        drive(4'hF, v1, 1'b1);
        check("lat_capture_valid", 32'(bus.o_valid), 32'd0);
        check("lat_capture_count", 32'(bus.o_count), 32'd1);
        drive(4'h0, '0, 1'b1);
        check("lat_pop_valid", 32'(bus.o_valid), 32'd1);
        check("lat_pop_data", 32'(bus.o_data), 32'h00100);
        check("lat_pop_count", 32'(bus.o_count), 32'd0);
        idle(5, 1'b1);
        check("single_idle", 32'(bus.o_valid), 32'd0);

        // Backpressure on lane 1
        vb = rand_vec();
        drive(4'hF, vb, 1'b0);
        drive(4'h0, '0, 1'b0);
        drive(4'h0, '0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(4'h0, '0, 1'b0);
            check("bp_lane_hold", 32'(bus.o_lane), 32'd1);
            check("bp_data_hold", 32'(bus.o_data), 32'(vb[1]));
        end
        drive(4'h0, '0, 1'b1);
        check("bp_lane2", 32'(bus.o_lane), 32'd2);
        drive(4'h0, '0, 1'b1);
        check("bp_lane3", 32'(bus.o_lane), 32'd3);
        check("bp_last", 32'(bus.o_last), 32'd1);
        drain();

        // Overflow
        do_reset();
        for (int i = 0; i < 6; i++) drive(4'hF, rand_vec(), 1'b0);
        check("ovf_count", 32'(bus.o_count), 32'd4);
        check("ovf_flag", 32'(bus.o_overflow), 32'd1);
        drain();
        check("ovf_sticky", 32'(bus.o_overflow), 32'd1);

        // Full FIFO with capture on the lane-3 handshake
        do_reset();
        for (int i = 0; i < 5; i++) drive(4'hF, rand_vec(), 1'b0);
        check("full_count", 32'(bus.o_count), 32'd4);
        idle(3, 1'b1);
        check("full_lane3", 32'(bus.o_lane), 32'd3);
        vnew = rand_vec();
        drive(4'hF, vnew, 1'b1);
        check("full_pop_count", 32'(bus.o_count), 32'd4);
        check("full_pop_ovf", 32'(bus.o_overflow), 32'd0);
        drain();

        // Lane mismatch
        do_reset();
        drive(4'b0101, rand_vec(), 1'b1);
        check("mis_flag", 32'(bus.o_lane_mismatch), 32'd1);
        check("mis_count", 32'(bus.o_count), 32'd0);
        idle(3, 1'b1);
        check("mis_no_beat", 32'(bus.o_valid), 32'd0);

        // Reset mid-transfer
        do_reset();
        for (int i = 0; i < 3; i++) drive(4'hF, rand_vec(), 1'b0);
        drive(4'b0011, rand_vec(), 1'b1);
        drive(4'h0, '0, 1'b1);
        check("rmid_lane2", 32'(bus.o_lane), 32'd2);
        check("rmid_count", 32'(bus.o_count), 32'd2);
        do_reset();
        check("rmid_valid", 32'(bus.o_valid), 32'd0);
        check("rmid_count0", 32'(bus.o_count), 32'd0);
        check("rmid_ovf", 32'(bus.o_overflow), 32'd0);
        check("rmid_mis", 32'(bus.o_lane_mismatch), 32'd0);
        drive(4'hF, rand_vec(), 1'b1);
        drain();

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            int r = $urandom_range(99);
            logic [3:0] v;
            if (r < 30) v = 4'hF;
            else if (r < 33) v = 4'($urandom_range(14, 1));
            else v = 4'h0;
            drive(v, rand_vec(), ($urandom_range(99) < 70));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
